// File: rtl/mul_dot_accumulator.sv
// Dot-product accumulator: sums N_TERMS consecutive multiplier products into a
// wide result with a sticky overflow flag, presented on a valid/ready output.
module mul_dot_accumulator #(
    parameter int unsigned PROD_W  = 32,
    parameter int unsigned ACC_W   = 40,
    parameter int unsigned N_TERMS = 4,
    localparam int unsigned CNT_W  = $clog2(N_TERMS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    input  logic              acc_clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf,
    output logic [CNT_W-1:0]  term_cnt
);

    localparam int unsigned SUM_W = ACC_W + 1;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic               r_ovf_acc;
    logic [CNT_W-1:0]   r_term_cnt;
    logic               r_out_valid;
    logic [ACC_W-1:0]   r_out_sum;
    logic               r_out_ovf;

    logic [SUM_W-1:0]   w_sum;
    logic               w_accept;
    logic               w_last;

    // Extra top bit of the sum is the carry out of the accumulator width.
    assign w_sum    = {1'b0, r_acc} + SUM_W'(in_product);
    assign in_ready = (r_state == ST_ACCUM) && !acc_clr;
    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_term_cnt == CNT_W'(N_TERMS - 1));

    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_ovf   = r_out_ovf;
    assign term_cnt  = r_term_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_ACCUM;
            r_acc       <= '0;
            r_ovf_acc   <= 1'b0;
            r_term_cnt  <= '0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_ovf   <= 1'b0;
        end else if (r_state == ST_ACCUM) begin
            if (acc_clr) begin
                r_acc      <= '0;
                r_ovf_acc  <= 1'b0;
                r_term_cnt <= '0;
            end else if (w_accept) begin
                if (w_last) begin
                    r_out_sum   <= w_sum[ACC_W-1:0];
                    r_out_ovf   <= r_ovf_acc | w_sum[ACC_W];
                    r_out_valid <= 1'b1;
                    r_acc       <= '0;
                    r_ovf_acc   <= 1'b0;
                    r_term_cnt  <= '0;
                    r_state     <= ST_HOLD;
                end else begin
                    r_acc      <= w_sum[ACC_W-1:0];
                    r_ovf_acc  <= r_ovf_acc | w_sum[ACC_W];
                    r_term_cnt <= r_term_cnt + CNT_W'(1);
                end
            end
        end else begin
            // Result held until downstream takes it; acc_clr is ignored here.
            if (out_ready) begin
                r_out_valid <= 1'b0;
                r_state     <= ST_ACCUM;
            end
        end
    end

endmodule

// File: tb/tb_mul_dot_accumulator.sv
// Bench for mul_dot_accumulator: three configurations driven in lockstep and
// checked against directed constants and a per-instance reference model.
module tb_mul_dot_accumulator;

    logic clk = 1'b0;
    logic rst, in_valid, acc_clr, out_ready;
    logic [31:0] in_product;

    logic       rdy0, v0, o0;  logic [39:0] s0; logic [2:0] c0;
    logic       rdy1, v1, o1;  logic [32:0] s1; logic [2:0] c1;
    logic       rdy2, v2, o2;  logic [39:0] s2; logic [0:0] c2;

    always #5 clk = ~clk;

    mul_dot_accumulator #(.PROD_W(32), .ACC_W(40), .N_TERMS(4)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
        .in_product(in_product), .acc_clr(acc_clr), .out_valid(v0),
        .out_ready(out_ready), .out_sum(s0), .out_ovf(o0), .term_cnt(c0));
    mul_dot_accumulator #(.PROD_W(32), .ACC_W(33), .N_TERMS(4)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
        .in_product(in_product), .acc_clr(acc_clr), .out_valid(v1),
        .out_ready(out_ready), .out_sum(s1), .out_ovf(o1), .term_cnt(c1));
    mul_dot_accumulator #(.PROD_W(32), .ACC_W(40), .N_TERMS(1)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2),
        .in_product(in_product), .acc_clr(acc_clr), .out_valid(v2),
        .out_ready(out_ready), .out_sum(s2), .out_ovf(o2), .term_cnt(c2));

    logic [63:0] a_sum[3], a_cnt[3];
    logic        a_v[3], a_o[3], a_r[3];
    assign a_sum[0] = 64'(s0); assign a_cnt[0] = 64'(c0);
    assign a_sum[1] = 64'(s1); assign a_cnt[1] = 64'(c1);
    assign a_sum[2] = 64'(s2); assign a_cnt[2] = 64'(c2);
    assign a_v[0] = v0; assign a_v[1] = v1; assign a_v[2] = v2;
    assign a_o[0] = o0; assign a_o[1] = o1; assign a_o[2] = o2;
    assign a_r[0] = rdy0; assign a_r[1] = rdy1; assign a_r[2] = rdy2;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;
    logic s_rdy[3];

    // Reference model: exact running total of accepted products per instance.
    int unsigned       acc_w[3] = '{40, 33, 40};
    int unsigned       n_t[3]   = '{4, 4, 1};
    longint unsigned   m_total[3];
    int unsigned       m_cnt[3];
    bit                m_v[3], m_o[3];
    longint unsigned   m_sum[3];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_total[d] = 0; m_cnt[d] = 0; m_v[d] = 1'b0; m_o[d] = 1'b0; m_sum[d] = 0;
        end
    endtask

    task automatic model_edge(input bit r, input bit iv, input logic [31:0] p,
                              input bit c, input bit ordy);
        longint unsigned lim;
        for (int d = 0; d < 3; d++) begin
            lim = 64'd1 << acc_w[d];
            if (r) begin
                m_total[d] = 0; m_cnt[d] = 0; m_v[d] = 1'b0; m_o[d] = 1'b0; m_sum[d] = 0;
            end else if (m_v[d]) begin
                if (ordy) m_v[d] = 1'b0;
            end else if (c) begin
                m_total[d] = 0; m_cnt[d] = 0;
            end else if (iv) begin
                m_total[d] += 64'(p);
                m_cnt[d]++;
                if (m_cnt[d] == n_t[d]) begin
                    m_sum[d]   = m_total[d] % lim;
                    m_o[d]     = (m_total[d] >= lim);
                    m_v[d]     = 1'b1;
                    m_total[d] = 0;
                    m_cnt[d]   = 0;
                end
            end
        end
    endtask

    // One clock: drive at negedge, check in_ready before the edge, outputs after.
    task automatic step(input bit r, input bit iv, input logic [31:0] p,
                        input bit c, input bit ordy);
        rst = r; in_valid = iv; in_product = p; acc_clr = c; out_ready = ordy;
        #1;
        for (int d = 0; d < 3; d++) begin
            s_rdy[d] = a_r[d];
            if (chk_en) chk($sformatf("dut%0d in_ready", d), 64'(a_r[d]), 64'(!m_v[d] && !c));
        end
        @(posedge clk);
        model_edge(r, iv, p, c, ordy);
        #1;
        if (chk_en) begin
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("dut%0d out_valid", d), 64'(a_v[d]), 64'(m_v[d]));
                chk($sformatf("dut%0d out_sum", d), a_sum[d], m_sum[d]);
                chk($sformatf("dut%0d out_ovf", d), 64'(a_o[d]), 64'(m_o[d]));
                chk($sformatf("dut%0d term_cnt", d), a_cnt[d], 64'(m_cnt[d]));
            end
        end
        @(negedge clk);
    endtask

    typedef struct {
        bit          r, iv;
        logic [31:0] p;
        bit          c, ordy;
        bit          e_rdy, e_v;
        logic [39:0] e_sum;
        bit          e_ovf;
        logic [2:0]  e_cnt;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input bit r, input bit iv, input logic [31:0] p, input bit c,
                       input bit ordy, input bit e_rdy, input bit e_v,
                       input logic [39:0] e_sum, input bit e_ovf, input logic [2:0] e_cnt);
        vec_t v;
        v.r = r; v.iv = iv; v.p = p; v.c = c; v.ordy = ordy; v.e_rdy = e_rdy;
        v.e_v = e_v; v.e_sum = e_sum; v.e_ovf = e_ovf; v.e_cnt = e_cnt;
        tbl.push_back(v);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_product = '0; acc_clr = 1'b0; out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        step(1, 0, 0, 0, 0);
        chk_en = 1'b1;

        // Basic sum, idle cycles, and acc_clr flush on the 40-bit / 4-term instance
        add(1, 0, 0,                0, 1, 1, 0, 40'd0,          0, 0);
        add(0, 1, 0,                0, 1, 1, 0, 40'd0,          0, 1);
        add(0, 1, 256,              0, 1, 1, 0, 40'd0,          0, 2);
        add(0, 1, 100,              0, 1, 1, 0, 40'd0,          0, 3);
        add(0, 1, 32'd4294836225,   0, 1, 1, 1, 40'd4294836581, 0, 0);
        add(0, 0, 0,                0, 1, 0, 0, 40'd4294836581, 0, 0);
        add(0, 0, 0,                0, 1, 1, 0, 40'd4294836581, 0, 0);
        add(0, 1, 16,               0, 1, 1, 0, 40'd4294836581, 0, 1);
        add(0, 0, 0,                0, 1, 1, 0, 40'd4294836581, 0, 1);
        add(0, 1, 16,               0, 1, 1, 0, 40'd4294836581, 0, 2);
        add(0, 1, 999,              1, 1, 0, 0, 40'd4294836581, 0, 0);
        add(0, 1, 58497,            0, 1, 1, 0, 40'd4294836581, 0, 1);
        add(0, 1, 1,                0, 1, 1, 0, 40'd4294836581, 0, 2);
        add(0, 1, 2,                0, 1, 1, 0, 40'd4294836581, 0, 3);
        add(0, 1, 3,                0, 1, 1, 1, 40'd58503,      0, 0);
        add(0, 0, 0,                0, 1, 0, 0, 40'd58503,      0, 0);
        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].iv, tbl[i].p, tbl[i].c, tbl[i].ordy);
            chk($sformatf("tbl%0d in_ready", i), 64'(s_rdy[0]), 64'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d out_valid", i), 64'(v0), 64'(tbl[i].e_v));
            chk($sformatf("tbl%0d out_sum", i), 64'(s0), 64'(tbl[i].e_sum));
            chk($sformatf("tbl%0d out_ovf", i), 64'(o0), 64'(tbl[i].e_ovf));
            chk($sformatf("tbl%0d term_cnt", i), 64'(c0), 64'(tbl[i].e_cnt));
        end

        // 33-bit accumulator: overflow is flagged, then cleared for the next result
        step(1, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 1, 32'd4294836225, 0, 1);
        chk("w33 ovf sum", 64'(s1), 64'd8589410308);
        chk("w33 ovf flag", 64'(o1), 64'd1);
        chk("w33 ovf valid", 64'(v1), 64'd1);
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 1);
        chk("w33 next sum", 64'(s1), 64'd4);
        chk("w33 next flag", 64'(o1), 64'd0);

        // Backpressure: result held while upstream keeps presenting a product
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 5, 0, 0);
        chk("bp result", 64'(s0), 64'd20);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 7, (i == 2), 0);
            chk("bp hold in_ready", 64'(s_rdy[0]), 64'd0);
            chk("bp hold valid", 64'(v0), 64'd1);
            chk("bp hold sum", 64'(s0), 64'd20);
        end
        step(0, 1, 7, 0, 1);
        chk("bp release valid", 64'(v0), 64'd0);
        step(0, 1, 7, 0, 1);
        chk("bp reopen in_ready", 64'(s_rdy[0]), 64'd1);
        chk("bp first term", 64'(c0), 64'd1);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 1);
        chk("bp next sum", 64'(s0), 64'd10);

        // Reset during HOLD and during a partial sum
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 3, 0, 0);
        chk("rst hold valid pre", 64'(v0), 64'd1);
        step(1, 1, 3, 0, 0);
        chk("rst hold valid", 64'(v0), 64'd0);
        chk("rst hold cnt", 64'(c0), 64'd0);
        for (int i = 0; i < 2; i++) step(0, 1, 3, 0, 1);
        chk("rst partial cnt pre", 64'(c0), 64'd2);
        step(1, 1, 3, 0, 1);
        chk("rst partial cnt", 64'(c0), 64'd0);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 10, 0, 1);
            chk("rst after in_ready", 64'(s_rdy[0]), 64'd1);
        end
        chk("rst after sum", 64'(s0), 64'd40);

        // Single-term configuration: every accept is a result
        step(1, 0, 0, 0, 1);
        step(0, 1, 7, 0, 1);
        chk("n1 first sum", 64'(s2), 64'd7);
        chk("n1 first valid", 64'(v2), 64'd1);
        step(0, 1, 9, 0, 1);
        chk("n1 held in_ready", 64'(s_rdy[2]), 64'd0);
        chk("n1 release valid", 64'(v2), 64'd0);
        step(0, 1, 9, 0, 1);
        chk("n1 second sum", 64'(s2), 64'd9);
        step(0, 0, 0, 0, 1);
        chk("n1 second held in_ready", 64'(s_rdy[2]), 64'd0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] p;
            p = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : 32'($urandom);
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), p,
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 1) == 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
